// File: rtl/iob_wait_ram.sv
// iob_wait_ram: native-bus responder RAM with a fixed number of wait states per access.
// The response is a registered one-cycle ready with read data; write strobes select bytes.
module iob_wait_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int WAIT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready
);
    localparam int NB = DATA_W / 8;
    localparam int AW = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [AW-1:0]     r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [NB-1:0]     r_wstrb, w_wstrb;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_ready, w_ready, w_enter, w_accept, w_unused;
    logic [DATA_W-1:0] r_mem [0:2**AW-1];

    assign w_unused = ^address[1:0];
    assign w_accept = (r_state == S_IDLE) && valid;

    // In IDLE the live bus is used directly, so WAIT=0 can complete on the accept edge.
    assign w_addr  = (r_state == S_IDLE) ? address[ADDR_W-1:2] : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    assign w_wstrb = (r_state == S_IDLE) ? wstrb : r_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_ready;
            r_rdata <= w_rdata;
            r_cnt   <= w_accept ? CNT_INIT
                     : (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
        end
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (valid ? ((WAIT == 0) ? S_RESP : S_WAIT) : S_IDLE)
               : (r_state == S_WAIT) ? ((r_cnt == 4'd0) ? S_RESP : S_WAIT)
               : S_IDLE;
    end

    always_comb begin
        w_enter = (w_next == S_RESP);
        w_ready = w_enter;
        w_rdata = (w_enter && w_wstrb == '0) ? r_mem[w_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= address[ADDR_W-1:2];
            r_wdata <= wdata;
            r_wstrb <= wstrb;
        end
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_enter && !rst)
            for (int i = 0; i < NB; i++)
                if (w_wstrb[i]) r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
endmodule

// File: tb/tb_iob_wait_ram.sv
// tb_iob_wait_ram: random and directed checks of two iob_wait_ram instances (WAIT=2 and WAIT=0)
// against a word-array model of the memory and the request/response timing rules.
module tb_iob_wait_ram;
    logic        clk = 1'b0;
    logic        rst     [2];
    logic        valid   [2];
    logic [11:0] address [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic [31:0] mdl [2][16];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iob_wait_ram #(.DATA_W(32), .ADDR_W(12), .WAIT(2)) u_dut2 (
        .clk(clk), .rst(rst[0]), .valid(valid[0]), .address(address[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .rdata(rdata[0]), .ready(ready[0])
    );
    iob_wait_ram #(.DATA_W(32), .ADDR_W(12), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst[1]), .valid(valid[1]), .address(address[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .rdata(rdata[1]), .ready(ready[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the IDLE cycle that follows ready.
    task automatic xact(input int d, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit drop);
        int w = (d == 0) ? 2 : 0;
        logic [31:0] exp_rd;
        exp_rd = (ws == 4'd0) ? mdl[d][a[5:2]] : 32'd0;
        for (int i = 0; i < 4; i++)
            if (ws[i]) mdl[d][a[5:2]][8*i +: 8] = wd[8*i +: 8];
        valid[d] = 1'b1; address[d] = a; wdata[d] = wd; wstrb[d] = ws;
        @(posedge clk);
        for (int n = 1; n <= w + 2; n++) begin
            @(negedge clk);
            check($sformatf("ready d%0d n%0d", d, n), {31'd0, ready[d]}, {31'd0, n == w + 1});
            check($sformatf("rdata d%0d n%0d", d, n), rdata[d], (n == w + 1) ? exp_rd : 32'd0);
            valid[d]   = (n <= w + 1) && !drop;
            address[d] = 12'($urandom);
            wdata[d]   = $urandom;
            wstrb[d]   = 4'($urandom);
        end
    endtask

    task automatic idle(input int d, input int k);
        valid[d] = 1'b0;
        repeat (k) begin
            @(negedge clk);
            check($sformatf("idle ready d%0d", d), {31'd0, ready[d]}, 32'd0);
            check($sformatf("idle rdata d%0d", d), rdata[d], 32'd0);
        end
    endtask

    task automatic pulse_rst(input int d, input bit with_valid);
        rst[d] = 1'b1; valid[d] = with_valid;
        address[d] = 12'h024; wdata[d] = 32'hBAD0BAD0; wstrb[d] = 4'hF;
        @(negedge clk);
        rst[d] = 1'b0; valid[d] = 1'b0;
        check($sformatf("rst ready d%0d", d), {31'd0, ready[d]}, 32'd0);
        check($sformatf("rst rdata d%0d", d), rdata[d], 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; address[d] = '0; wdata[d] = '0; wstrb[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset ready", {31'd0, ready[d]}, 32'd0);
            check("reset rdata", rdata[d], 32'd0);
            rst[d] = 1'b0;
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) xact(d, 12'(i * 4), $urandom, 4'hF, 1'b0);
        // full write then read, partial-strobe merge
        xact(0, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0);
        xact(0, 12'h010, 32'h0, 4'h0, 1'b0);
        xact(0, 12'h010, 32'h11223344, 4'h5, 1'b1);
        xact(0, 12'h010, 32'h0, 4'h0, 1'b1);
        idle(0, 3);
        // reset in the first WAIT cycle discards the write
        valid[0] = 1'b1; address[0] = 12'h020; wdata[0] = 32'h55AA55AA; wstrb[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        pulse_rst(0, 1'b0);
        idle(0, 4);
        xact(0, 12'h020, 32'h0, 4'h0, 1'b0);
        // valid during reset is not accepted
        pulse_rst(0, 1'b1);
        idle(0, 4);
        xact(0, 12'h024, 32'h0, 4'h0, 1'b0);
        // WAIT=0 back-to-back write then read
        xact(1, 12'h000, 32'h1, 4'hF, 1'b0);
        xact(1, 12'h000, 32'h0, 4'h0, 1'b0);
        idle(1, 2);
        // address aliasing and memory retention across reset
        for (int d = 0; d < 2; d++) begin
            xact(d, 12'h013, 32'hCAFEF00D, 4'hF, 1'b0);
            pulse_rst(d, 1'b0);
            xact(d, 12'h010, 32'h0, 4'h0, 1'b0);
        end
        for (int k = 0; k < 300; k++) begin
            int d = int'($urandom_range(1));
            xact(d, 12'($urandom_range(63)), $urandom,
                 ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), bit'($urandom_range(1)));
            if ($urandom_range(3) == 0) idle(d, int'($urandom_range(2)));
        end
        idle(0, 2);
        idle(1, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
